// File: rtl/reg_read_bypass_pkg.sv
// Shared core parameters for the issue, reg-read and execute stages.
package reg_read_bypass_pkg;

    localparam int CORE_LANES    = 6;
    localparam int CORE_PKT_W    = 96;
    localparam int CORE_PHYS_LOG = 7;
    localparam int CORE_DATA_W   = 32;
    localparam int CORE_CKPTS    = 4;
    localparam int CORE_WB       = 4;

    // Width of a checkpoint index; a single checkpoint still needs one bit
    function automatic int ckptIdxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_read_bypass_operand.sv
// rr_operand_select: one source operand of one lane -- writeback compare,
// early-bypass latch, priority mux and stall hold register.
module rr_operand_select
    import reg_read_bypass_pkg::*;
#(
    parameter int PHYS_LOG = CORE_PHYS_LOG,
    parameter int DATA_W   = CORE_DATA_W,
    parameter int WB       = CORE_WB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_i,
    input  logic [PHYS_LOG-1:0]    srcTag_i,
    input  logic [WB-1:0]          wbValid_i,
    input  logic [WB*PHYS_LOG-1:0] wbTag_i,
    input  logic [WB*DATA_W-1:0]   wbData_i,
    input  logic [DATA_W-1:0]      prfData_i,
    output logic [DATA_W-1:0]      data_o
);

    logic [PHYS_LOG-1:0] tagA;
    logic                earlyHit;
    logic                resolved;
    logic [DATA_W-1:0]   earlyData;
    logic [DATA_W-1:0]   holdData;
    logic                inHit;
    logic [DATA_W-1:0]   inData;
    logic                curHit;
    logic [DATA_W-1:0]   curData;

    // Writeback compare for the incoming tag and the stage A tag; lowest port wins
    always_comb begin
        inHit   = 1'b0;
        inData  = '0;
        curHit  = 1'b0;
        curData = '0;
        for (int unsigned i = 0; i < WB; i++) begin
            if (!inHit && wbValid_i[i] && (wbTag_i[i*PHYS_LOG +: PHYS_LOG] == srcTag_i)) begin
                inHit  = 1'b1;
                inData = wbData_i[i*DATA_W +: DATA_W];
            end
            if (!curHit && wbValid_i[i] && (wbTag_i[i*PHYS_LOG +: PHYS_LOG] == tagA)) begin
                curHit  = 1'b1;
                curData = wbData_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Operand priority: live writeback, early bypass, then hold register or PRF
    always_comb begin
        if (curHit) begin
            data_o = curData;
        end else if (earlyHit) begin
            data_o = earlyData;
        end else if (resolved) begin
            data_o = holdData;
        end else begin
            data_o = prfData_i;
        end
    end

    // Control flags: early hit captured with the lane, resolved set on first stall cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            earlyHit <= 1'b0;
            resolved <= 1'b0;
        end else if (!stall_i) begin
            earlyHit <= inHit;
            resolved <= 1'b0;
        end else begin
            resolved <= 1'b1;
        end
    end

    // Payload: tag and early data follow the lane; hold register snapshots the resolved operand
    always_ff @(posedge clk) begin
        if (!stall_i) begin
            tagA      <= srcTag_i;
            earlyData <= inData;
        end else if (!resolved) begin
            holdData <= data_o;
        end
    end

endmodule

// File: rtl/reg_read_bypass.sv
// reg_read_bypass: two-stage register read (PRF return, output registers)
// with writeback bypass, stall hold and branch checkpoint flush/clear.
module reg_read_bypass
    import reg_read_bypass_pkg::*;
#(
    parameter int  LANES    = CORE_LANES,
    parameter int  PKT_W    = CORE_PKT_W,
    parameter int  PHYS_LOG = CORE_PHYS_LOG,
    parameter int  DATA_W   = CORE_DATA_W,
    parameter int  CKPTS    = CORE_CKPTS,
    parameter int  WB       = CORE_WB,
    localparam int CKPT_W   = ckptIdxWidth(CKPTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES-1:0]          grantedValid_i,
    input  logic [LANES*PKT_W-1:0]    grantedPacket_i,
    input  logic [LANES*PHYS_LOG-1:0] src1Tag_i,
    input  logic [LANES*PHYS_LOG-1:0] src2Tag_i,
    input  logic [LANES*CKPTS-1:0]    ckptMask_i,
    output logic [LANES*PHYS_LOG-1:0] prfAddr1_o,
    output logic [LANES*PHYS_LOG-1:0] prfAddr2_o,
    input  logic [LANES*DATA_W-1:0]   prfData1_i,
    input  logic [LANES*DATA_W-1:0]   prfData2_i,
    input  logic [WB-1:0]             wbValid_i,
    input  logic [WB*PHYS_LOG-1:0]    wbTag_i,
    input  logic [WB*DATA_W-1:0]      wbData_i,
    input  logic                      brValid_i,
    input  logic                      brMispred_i,
    input  logic [CKPT_W-1:0]         brCkpt_i,
    input  logic                      stall_i,
    output logic [LANES-1:0]          valid_o,
    output logic [LANES*PKT_W-1:0]    packet_o,
    output logic [LANES*DATA_W-1:0]   src1Data_o,
    output logic [LANES*DATA_W-1:0]   src2Data_o,
    output logic [LANES*CKPTS-1:0]    ckptMask_o
);

    logic              kill;
    logic [CKPTS-1:0]  clrMask;
    logic [PKT_W-1:0]  inPacket [LANES];
    logic [CKPTS-1:0]  inMask   [LANES];
    logic [LANES-1:0]  validA;
    logic [PKT_W-1:0]  packetA  [LANES];
    logic [CKPTS-1:0]  ckptA    [LANES];
    logic [DATA_W-1:0] op1      [LANES];
    logic [DATA_W-1:0] op2      [LANES];
    logic [PKT_W-1:0]  packetB  [LANES];
    logic [CKPTS-1:0]  ckptB    [LANES];
    logic [DATA_W-1:0] data1B   [LANES];
    logic [DATA_W-1:0] data2B   [LANES];

    assign prfAddr1_o = src1Tag_i;
    assign prfAddr2_o = src2Tag_i;

    for (genvar g = 0; g < LANES; g++) begin : gLane
        assign inPacket[g] = grantedPacket_i[g*PKT_W +: PKT_W];
        assign inMask[g]   = ckptMask_i[g*CKPTS +: CKPTS];

        rr_operand_select #(.PHYS_LOG(PHYS_LOG), .DATA_W(DATA_W), .WB(WB)) uSrc1 (
            .clk       (clk),
            .reset     (reset),
            .stall_i   (stall_i),
            .srcTag_i  (src1Tag_i[g*PHYS_LOG +: PHYS_LOG]),
            .wbValid_i (wbValid_i),
            .wbTag_i   (wbTag_i),
            .wbData_i  (wbData_i),
            .prfData_i (prfData1_i[g*DATA_W +: DATA_W]),
            .data_o    (op1[g])
        );

        rr_operand_select #(.PHYS_LOG(PHYS_LOG), .DATA_W(DATA_W), .WB(WB)) uSrc2 (
            .clk       (clk),
            .reset     (reset),
            .stall_i   (stall_i),
            .srcTag_i  (src2Tag_i[g*PHYS_LOG +: PHYS_LOG]),
            .wbValid_i (wbValid_i),
            .wbTag_i   (wbTag_i),
            .wbData_i  (wbData_i),
            .prfData_i (prfData2_i[g*DATA_W +: DATA_W]),
            .data_o    (op2[g])
        );

        assign packet_o[g*PKT_W +: PKT_W]     = packetB[g];
        assign src1Data_o[g*DATA_W +: DATA_W] = data1B[g];
        assign src2Data_o[g*DATA_W +: DATA_W] = data2B[g];
        assign ckptMask_o[g*CKPTS +: CKPTS]   = ckptB[g];
    end

    // Branch resolution: mispredict kills matching lanes, correct prediction retires the checkpoint bit
    always_comb begin
        kill    = brValid_i && brMispred_i;
        clrMask = '0;
        if (brValid_i && !brMispred_i) begin
            clrMask[brCkpt_i] = 1'b1;
        end
    end

    // Stage A valid bits: capture when not stalled, flush applies in both cases
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validA <= '0;
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (!stall_i) begin
                    validA[l] <= grantedValid_i[l] && !(kill && inMask[l][brCkpt_i]);
                end else if (kill && ckptA[l][brCkpt_i]) begin
                    validA[l] <= 1'b0;
                end
            end
        end
    end

    // Stage A payload; mask clearing continues while stalled
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (!stall_i) begin
                packetA[l] <= inPacket[l];
                ckptA[l]   <= inMask[l] & ~clrMask;
            end else begin
                ckptA[l]   <= ckptA[l] & ~clrMask;
            end
        end
    end

    // Stage B output registers: advance from stage A unless stalled; flush and mask clear always apply
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_o <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                packetB[l] <= '0;
                ckptB[l]   <= '0;
                data1B[l]  <= '0;
                data2B[l]  <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (!stall_i) begin
                    valid_o[l] <= validA[l] && !(kill && ckptA[l][brCkpt_i]);
                    packetB[l] <= packetA[l];
                    ckptB[l]   <= ckptA[l] & ~clrMask;
                    data1B[l]  <= op1[l];
                    data2B[l]  <= op2[l];
                end else begin
                    valid_o[l] <= valid_o[l] && !(kill && ckptB[l][brCkpt_i]);
                    ckptB[l]   <= ckptB[l] & ~clrMask;
                end
            end
        end
    end

endmodule
